// File: rtl/ps2_pkg.sv
// Shared PS/2 keyboard definitions: receiver states, prefix codes and the
// scan-code to piano-key table.
package ps2_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } rx_state_t;

    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE   = 8'hE0;

    localparam int KEY_COUNT = 12;

    localparam logic [7:0] KEY_TABLE [KEY_COUNT] = '{
        8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33,
        8'h3B, 8'h42, 8'h4B, 8'h3C, 8'h43, 8'h44
    };

    // Returns {hit, index}; hit=0 for codes outside the table.
    function automatic logic [4:0] key_lookup(input logic [7:0] code);
        logic [4:0] r;
        r = '0;
        for (int i = 0; i < KEY_COUNT; i++) begin
            if (KEY_TABLE[i] == code) r = {1'b1, 4'(i)};
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 byte receiver: synchroniser, falling-edge strobe, frame FSM,
// odd-parity check and inter-edge timeout.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps_clk,
    input  logic       ps_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYCLES);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   clk_cur;
    logic                   data_cur;
    logic                   strobe;

    rx_state_t     state_q;
    rx_state_t     state_d;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par_bit;
    logic [CW-1:0] cnt;
    logic          timeout;

    assign clk_cur  = clk_sync[SYNC_STAGES-1];
    assign data_cur = data_sync[SYNC_STAGES-1];
    assign strobe   = clk_prev & ~clk_cur;

    // Presetting to 1 keeps reset exit from looking like a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps_data};
            clk_prev  <= clk_cur;
        end
    end

    always_comb begin
        state_d = state_q;
        timeout = (state_q != S_IDLE) && !strobe && (cnt == TO_MAX);
        if (timeout) begin
            state_d = S_IDLE;
        end else if (strobe) begin
            unique case (state_q)
                S_IDLE:   if (!data_cur) state_d = S_DATA;
                S_DATA:   if (bit_cnt == 3'd7) state_d = S_PARITY;
                S_PARITY: state_d = S_STOP;
                S_STOP:   state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt    <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            cnt        <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;

            if (strobe) cnt <= CW'(1);
            else if (state_q == S_IDLE) cnt <= '0;
            else cnt <= cnt + CW'(1);

            if (timeout) begin
                frame_err <= 1'b1;
            end else if (strobe) begin
                unique case (state_q)
                    S_IDLE: bit_cnt <= '0;
                    S_DATA: begin
                        shift   <= {data_cur, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    S_PARITY: par_bit <= data_cur;
                    S_STOP: begin
                        // A bad stop bit outranks a parity fault.
                        if (!data_cur) begin
                            frame_err <= 1'b1;
                        end else if (^{shift, par_bit}) begin
                            rx_byte    <= shift;
                            byte_valid <= 1'b1;
                        end else begin
                            parity_err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_poly_keyboard.sv
// Polyphonic PS/2 piano keyboard: decodes make/break codes from ps2_rx
// into per-key held bits and press/release events.
module ps2_poly_keyboard
    import ps2_pkg::*;
#(
    parameter int NUM_KEYS       = 12,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ps_clk,
    input  logic                ps_data,
    output logic [NUM_KEYS-1:0] key_held,
    output logic                key_event,
    output logic [3:0]          key_idx,
    output logic                key_on,
    output logic [7:0]          scan_code,
    output logic                byte_valid,
    output logic                parity_err,
    output logic                frame_err
);

    logic                break_pend;
    logic                ext_pend;
    logic [4:0]          hit;
    logic                mapped;
    logic [NUM_KEYS-1:0] mask;

    ps2_rx #(
        .SYNC_STAGES   (SYNC_STAGES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps_clk    (ps_clk),
        .ps_data   (ps_data),
        .rx_byte   (scan_code),
        .byte_valid(byte_valid),
        .parity_err(parity_err),
        .frame_err (frame_err)
    );

    assign hit    = key_lookup(scan_code);
    assign mapped = hit[4] && (int'(hit[3:0]) < NUM_KEYS);
    assign mask   = mapped ? (NUM_KEYS'(1) << hit[3:0]) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            break_pend <= 1'b0;
            ext_pend   <= 1'b0;
            key_held   <= '0;
            key_event  <= 1'b0;
            key_idx    <= '0;
            key_on     <= 1'b0;
        end else begin
            key_event <= 1'b0;
            if (parity_err || frame_err) begin
                break_pend <= 1'b0;
                ext_pend   <= 1'b0;
            end else if (byte_valid) begin
                if (scan_code == BREAK_CODE) begin
                    break_pend <= 1'b1;
                end else if (scan_code == EXT_CODE) begin
                    ext_pend <= 1'b1;
                end else begin
                    break_pend <= 1'b0;
                    ext_pend   <= 1'b0;
                    // Extended keys are not piano keys.
                    if (!ext_pend && mapped) begin
                        if (!break_pend && !(|(key_held & mask))) begin
                            key_held  <= key_held | mask;
                            key_event <= 1'b1;
                            key_idx   <= hit[3:0];
                            key_on    <= 1'b1;
                        end else if (break_pend && |(key_held & mask)) begin
                            key_held  <= key_held & ~mask;
                            key_event <= 1'b1;
                            key_idx   <= hit[3:0];
                            key_on    <= 1'b0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: doc/ps2_poly_keyboard.md
PS2_POLY_KEYBOARD -- requirements
Module: ps2_poly_keyboard

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 12, meaning the number of tracked piano keys, legal range 1..12.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning the synchroniser depth on ps_clk and ps_data, legal range 2..4.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 50000, meaning the maximum clk cycles allowed between ps_clk falling edges inside a frame.
REQ-004 SHALL have port clk, input, 1, the system clock; the block uses one clock.
REQ-005 SHALL have port rst_n, input, 1, the reset; reset is asynchronous and active-low.
REQ-006 SHALL have port ps_clk, input, 1, the raw PS/2 clock; it is asynchronous and is never used as a clock.
REQ-007 SHALL have port ps_data, input, 1, the raw PS/2 data line.
REQ-008 SHALL have port key_held, output, NUM_KEYS, where bit i=1 means key i is currently pressed.
REQ-009 SHALL have port key_event, output, 1, a one-cycle pulse on each key state change.
REQ-010 SHALL have port key_idx, output, 4, the key index for key_event, valid only while key_event=1.
REQ-011 SHALL have port key_on, output, 1, where 1 means press and 0 means release, valid only while key_event=1.
REQ-012 SHALL have port scan_code, output, 8, the last correctly received byte; it holds until the next good byte.
REQ-013 SHALL have port byte_valid, output, 1, a one-cycle pulse when scan_code updates.
REQ-014 SHALL have port parity_err, output, 1, a one-cycle pulse.
REQ-015 SHALL have port frame_err, output, 1, a one-cycle pulse.

Function
REQ-016 SHALL pass ps_clk and ps_data through SYNC_STAGES flops, and SHALL detect a falling edge on the synchronised ps_clk (prev=1, cur=0) as a one-cycle sample strobe.
REQ-017 SHALL implement a frame FSM with states IDLE, DATA, PARITY and STOP, advancing only on the sample strobe:
  - IDLE: on data=0 go to DATA with bit count 0; on data=1 stay in IDLE.
  - DATA: shift data in LSB first; after 8 bits go to PARITY.
  - PARITY: capture the parity bit and go to STOP.
  - STOP: go to IDLE.
REQ-018 SHALL treat a frame as good when the stop bit is 1 and the 8 data bits plus the parity bit contain an odd number of ones.
REQ-019 SHALL, for a good frame, update scan_code and pulse byte_valid in the cycle after the stop-bit strobe.
REQ-020 SHALL, when parity is wrong, pulse parity_err, discard the byte, and clear both prefix flags.
REQ-021 SHALL, when the stop bit is 0, pulse frame_err, discard the byte, and clear both prefix flags; when both faults occur, only frame_err pulses.
REQ-022 SHALL, in any non-IDLE state, count clk cycles since the last strobe; on reaching TIMEOUT_CYCLES it SHALL return to IDLE, pulse frame_err once, and clear the prefix flags.
REQ-023 SHALL decode each good byte in the cycle after byte_valid:
  - 0xF0: set break_pend.
  - 0xE0: set ext_pend.
  - Any other byte with ext_pend=1: clear both flags, no key change.
  - Any other byte: map it via the key table, then clear both flags.
REQ-024 SHALL use this key table: 1C→0, 1B→1, 23→2, 2B→3, 34→4, 33→5, 3B→6, 42→7, 4B→8, 3C→9, 43→10, 44→11; unmapped codes and indices ≥ NUM_KEYS SHALL be ignored.
REQ-025 SHALL handle a mapped key press (break_pend=0) as follows:
  - If the key bit is 0: set it and pulse key_event with key_on=1.
  - If the key bit is already 1 (typematic repeat): produce no event.
REQ-026 SHALL handle a mapped key release (break_pend=1) as follows:
  - If the key bit is 1: clear it and pulse key_event with key_on=0.
  - If the key bit is 0: produce no event.
REQ-027 SHALL pulse key_event exactly two clk cycles after the stop-bit strobe, and SHALL not pulse it more than once per byte.
REQ-028 SHALL keep key_held changes independent per bit, so any number of keys can be held at once.

Reset
REQ-029 SHALL, while rst_n=0, drive the FSM to IDLE and clear to 0: the counters, the shift register, both prefix flags, key_held, key_event, key_idx, key_on, scan_code, byte_valid, parity_err and frame_err.
REQ-030 SHALL preset the synchroniser flops and the previous-ps_clk flop to 1 during reset, so that no false edge occurs on exit.
REQ-031 SHALL abandon a frame that is mid-reception when reset asserts; when reset deasserts, it SHALL wait in IDLE for a new start bit.

Structure
REQ-032 SHALL place the key table, the prefix constants (0xF0, 0xE0) and the FSM state enum in the shared package ps2_pkg.
REQ-033 SHALL place the synchroniser, edge detect, frame FSM, parity check and timeout in sub-module ps2_rx, which outputs byte, byte_valid, parity_err and frame_err; ps2_poly_keyboard SHALL contain only the decode logic and the key_held logic.

Verification
REQ-034 SHALL cover a single key press and release: send 0x1C, then F0 and 1C.
  - Required: key_event with idx 0 and on=1, then idx 0 and on=0.
  - Required: key_held is 0x001 after the press and 0x000 at the end.
REQ-035 SHALL cover polyphony: send 1C, 23, 44, then F0 and 23.
  - Required: key_held goes 0x001 → 0x005 → 0x805 → 0x801.
  - Required: exactly 4 key_event pulses.
REQ-036 SHALL cover typematic repeat: send 1B three times.
  - Required: exactly one key_event (idx 1, on=1).
  - Required: byte_valid pulses 3 times.
REQ-037 SHALL cover parity error: send 0x1C with even parity.
  - Required: one parity_err pulse.
  - Required: no byte_valid pulse, and key_held stays 0.
REQ-038 SHALL cover timeout: stop ps_clk after 4 data bits.
  - Required: frame_err pulses TIMEOUT_CYCLES cycles after the last edge.
  - Required: the next full frame 0x1C is decoded normally.
REQ-039 SHALL cover the extended-prefix and NUM_KEYS limits.
  - With NUM_KEYS=12, send E0 and 1C: no key change.
  - With NUM_KEYS=4, send 0x44: byte_valid pulses, no key_event.
